hi_reg_term: RTL

Register-bank terminal on the Host Interface device bus, sitting directly downstream of the host arbiter. It decodes one terminal address and serves multi-word writes and reads against a bank of 32-bit registers with auto-incrementing register pointers. It drives the `di_*_rdy`, `di_reg_datao` and `di_transfer_status` returns, and exports the register contents and per-register write strobes to fabric logic.

---
 rtl/hi_reg_term.sv | 106 ++++++++++
 1 files changed

// File: rtl/hi_reg_term.sv
// hi_reg_term: host-bus register-bank terminal serving multi-word reads/writes with an auto-incrementing pointer
module hi_reg_term #(
  parameter logic [15:0]         TERM_ADDR = 16'h0010,
  parameter int                  NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
  input  logic                    ifclk,
  input  logic                    resetb,
  input  logic [15:0]             di_term_addr,
  input  logic [31:0]             di_reg_addr,
  input  logic [31:0]             di_len,
  input  logic                    di_write_mode,
  input  logic                    di_write,
  input  logic [31:0]             di_reg_datai,
  output logic                    di_write_rdy,
  input  logic                    di_read_mode,
  input  logic                    di_read_req,
  input  logic                    di_read,
  output logic                    di_read_rdy,
  output logic [31:0]             di_reg_datao,
  output logic [15:0]             di_transfer_status,
  input  logic [32*NUM_REGS-1:0]  ro_data,
  output logic [32*NUM_REGS-1:0]  regs_q,
  output logic [NUM_REGS-1:0]     wr_strobe
);
  typedef enum logic [1:0] {IDLE, WRITE, RD_FETCH, RD_VALID} state_t;
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] NR = 32'(NUM_REGS);
  state_t state;
  logic [31:0] ptr, cnt, ptr_nx, cnt_nx, datao, word, word_nx;
  logic [31:0] regs [NUM_REGS];
  logic [1:0] status;
  logic write_rdy, read_rdy, sel, active, over, in_rng, in_rng_nx;
  logic [IW-1:0] idx, idx_nx;
  assign sel       = di_term_addr == TERM_ADDR;
  assign active    = sel && (state == WRITE ? di_write_mode : di_read_mode);
  assign ptr_nx    = &ptr ? ptr : ptr + 32'd1;
  assign cnt_nx    = &cnt ? cnt : cnt + 32'd1;
  assign over      = cnt >= di_len;
  assign idx       = ptr[IW-1:0];
  assign idx_nx    = ptr_nx[IW-1:0];
  assign in_rng    = ptr < NR;
  assign in_rng_nx = ptr_nx < NR;
  assign word      = !in_rng ? 32'hDEADBEEF : RO_MASK[idx] ? ro_data[{idx, 5'd0} +: 32] : regs[idx];
  assign word_nx   = !in_rng_nx ? 32'hDEADBEEF : RO_MASK[idx_nx] ? ro_data[{idx_nx, 5'd0} +: 32] : regs[idx_nx];
  assign di_write_rdy       = sel && write_rdy;
  assign di_read_rdy        = sel && read_rdy;
  assign di_reg_datao       = sel ? datao : 32'd0;
  assign di_transfer_status = sel ? {14'd0, status} : 16'd0;
  for (genvar i = 0; i < NUM_REGS; i++) assign regs_q[32*i +: 32] = regs[i];
  always_ff @(posedge ifclk) begin
    wr_strobe <= '0;
    if (!resetb) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      status    <= '0;
      datao     <= '0;
      write_rdy <= 1'b0;
      read_rdy  <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (state != IDLE && !active) begin
      state     <= IDLE;
      write_rdy <= 1'b0;
      read_rdy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sel && (di_write_mode || di_read_mode)) begin
          state     <= di_write_mode ? WRITE : RD_FETCH;
          write_rdy <= di_write_mode;
          ptr       <= di_reg_addr;
          cnt       <= '0;
          status    <= '0;
        end
        WRITE: if (di_write) begin
          if (over) status[1] <= 1'b1;
          if (!in_rng) status[0] <= 1'b1;
          if (!over && in_rng && !RO_MASK[idx]) begin
            regs[idx]      <= di_reg_datai;
            wr_strobe[idx] <= 1'b1;
          end
          ptr <= ptr_nx;
          cnt <= cnt_nx;
        end
        RD_FETCH: if (di_read_req) begin
          datao    <= word;
          read_rdy <= 1'b1;
          state    <= RD_VALID;
          if (!in_rng) status[0] <= 1'b1;
        end
        RD_VALID: if (di_read) begin
          ptr <= ptr_nx;
          cnt <= cnt_nx;
          if (over) status[1] <= 1'b1;
          if (di_read_req) begin
            datao <= word_nx;
            if (!in_rng_nx) status[0] <= 1'b1;
          end else begin
            read_rdy <= 1'b0;
            state    <= RD_FETCH;
          end
        end
      endcase
    end
  end
endmodule
